// File: rtl/imem_latency_model.sv
// Instruction memory with a fixed fetch latency. Each fetch is accepted in IDLE,
// waits in WAIT, and completes with a one-cycle Ack strobe in ACK.
module imem_latency_model #(
  parameter int          DEPTH     = 1024,
  parameter logic [29:0] BASE_ADDR = 30'h400,
  parameter int          LATENCY   = 3,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [29:0]   InstMem_Address,
  input  logic          InstMem_Read,
  output logic [31:0]   InstMem_In,
  output logic          InstMem_Ack,
  output logic          InstMem_Fault,
  input  logic          Load_En,
  input  logic [AW-1:0] Load_Addr,
  input  logic [31:0]   Load_Data,
  output logic [15:0]   Req_Count
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  logic [31:0] mem [DEPTH];
  state_t      state;
  logic [3:0]  cnt;
  logic [29:0] addr_q;

  logic [29:0] fetch_addr;
  logic [29:0] fetch_idx;
  logic        fetch_fault;
  logic        enter_ack;

  // With LATENCY=1 the ACK-entry edge is the accepting edge, so the live address is used.
  always_comb begin
    fetch_addr  = (state == IDLE) ? InstMem_Address : addr_q;
    fetch_idx   = fetch_addr - BASE_ADDR;
    fetch_fault = (fetch_idx >= DEPTH_W);
    enter_ack   = 1'b0;
    if (InstMem_Read) begin
      if (state == IDLE && LATENCY == 1) enter_ack = 1'b1;
      if (state == WAIT && cnt == 4'd1)  enter_ack = 1'b1;
    end
  end

  // Memory is never reset; loads are honoured in every state, including reset.
  always_ff @(posedge clock) begin
    if (Load_En) mem[Load_Addr] <= Load_Data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      addr_q        <= 30'd0;
      InstMem_Ack   <= 1'b0;
      InstMem_Fault <= 1'b0;
      InstMem_In    <= 32'h0;
      Req_Count     <= 16'd0;
    end else begin
      InstMem_Ack   <= 1'b0;
      InstMem_Fault <= 1'b0;
      case (state)
        IDLE: begin
          if (InstMem_Read) begin
            addr_q <= InstMem_Address;
            cnt    <= CNT_INIT;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (!InstMem_Read) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
      // Read-first: the memory write above lands after this read at the same edge.
      if (enter_ack) begin
        state         <= ACK;
        cnt           <= 4'd0;
        InstMem_Ack   <= 1'b1;
        InstMem_Fault <= fetch_fault;
        InstMem_In    <= fetch_fault ? NOP_WORD : mem[fetch_idx[AW-1:0]];
        if (Req_Count != 16'hFFFF) Req_Count <= Req_Count + 16'd1;
      end
    end
  end

endmodule
